// File: rtl/rs_wakeup_select_if.sv
// Dispatch, CDB, squash and issue bundle for the unified reservation station.
// The master side (dispatch/issue logic) drives requests; the slave side (the RS) drives status and issue.
interface rs_wakeup_select_if #(
    parameter int RS_SZ    = 8,
    parameter int FU_TYPES = 4,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 5
);
    localparam int FU_W  = $clog2(FU_TYPES);
    localparam int CNT_W = $clog2(RS_SZ) + 1;

    logic                       disp_en;
    logic [FU_W-1:0]            disp_fu;
    logic [PREG_W-1:0]          disp_t1;
    logic                       disp_t1_rdy;
    logic [PREG_W-1:0]          disp_t2;
    logic                       disp_t2_rdy;
    logic [PREG_W-1:0]          disp_dest;
    logic [ROB_W-1:0]           disp_rob;
    logic                       disp_ready;
    logic [CNT_W-1:0]           free_cnt;
    logic                       cdb_en;
    logic [PREG_W-1:0]          cdb_tag;
    logic [FU_TYPES-1:0]        fu_busy;
    logic                       squash;
    logic [FU_TYPES-1:0]        iss_valid;
    logic [FU_TYPES*PREG_W-1:0] iss_dest;
    logic [FU_TYPES*PREG_W-1:0] iss_t1;
    logic [FU_TYPES*PREG_W-1:0] iss_t2;
    logic [FU_TYPES*ROB_W-1:0]  iss_rob;

    modport master (
        output disp_en, disp_fu, disp_t1, disp_t1_rdy, disp_t2, disp_t2_rdy,
               disp_dest, disp_rob, cdb_en, cdb_tag, fu_busy, squash,
        input  disp_ready, free_cnt, iss_valid, iss_dest, iss_t1, iss_t2, iss_rob
    );

    modport slave (
        input  disp_en, disp_fu, disp_t1, disp_t1_rdy, disp_t2, disp_t2_rdy,
               disp_dest, disp_rob, cdb_en, cdb_tag, fu_busy, squash,
        output disp_ready, free_cnt, iss_valid, iss_dest, iss_t1, iss_t2, iss_rob
    );
endinterface

// File: rtl/rs_wakeup_select.sv
// Unified reservation station: CDB tag wakeup and oldest-ready select per FU class.
// Optional macro RS_CDB_BYPASS_EN lets a same-cycle CDB match count as ready (one cycle earlier issue).
module rs_wakeup_select #(
    parameter int RS_SZ    = 8,
    parameter int FU_TYPES = 4,
    parameter int PREG_W   = 6,
    parameter int ROB_W    = 5
) (
    input  logic              clock,
    input  logic              reset,
    rs_wakeup_select_if.slave rs
);
    localparam int IDX_W = $clog2(RS_SZ);
    localparam int CNT_W = IDX_W + 1;
    localparam int FU_W  = $clog2(FU_TYPES);

    // Entry storage
    logic [RS_SZ-1:0]           valid_r;
    logic [RS_SZ-1:0]           r1_r;
    logic [RS_SZ-1:0]           r2_r;
    logic [FU_W-1:0]            fu_r   [RS_SZ];
    logic [PREG_W-1:0]          t1_r   [RS_SZ];
    logic [PREG_W-1:0]          t2_r   [RS_SZ];
    logic [PREG_W-1:0]          dest_r [RS_SZ];
    logic [ROB_W-1:0]           rob_r  [RS_SZ];
    logic [IDX_W-1:0]           rank_r [RS_SZ];

    // Registered outputs
    logic [CNT_W-1:0]           free_cnt_r;
    logic                       disp_ready_r;
    logic [FU_TYPES-1:0]        iss_valid_r;
    logic [FU_TYPES*PREG_W-1:0] iss_dest_r;
    logic [FU_TYPES*PREG_W-1:0] iss_t1_r;
    logic [FU_TYPES*PREG_W-1:0] iss_t2_r;
    logic [FU_TYPES*ROB_W-1:0]  iss_rob_r;

    // Next-state terms
    logic                       clear_s;
    logic [RS_SZ-1:0]           m1_s;
    logic [RS_SZ-1:0]           m2_s;
    logic [RS_SZ-1:0]           rdy_s;
    logic [RS_SZ-1:0]           issue_s;
    logic [FU_TYPES-1:0]        sel_vld_s;
    logic [IDX_W-1:0]           sel_idx_s [FU_TYPES];
    logic [CNT_W-1:0]           n_iss_s;
    logic [CNT_W-1:0]           vcnt_s;
    logic [IDX_W-1:0]           new_rank_s;
    logic [IDX_W-1:0]           dec_s [RS_SZ];
    logic                       disp_fire_s;
    logic [IDX_W-1:0]           free_idx_s;
    logic                       d_r1_s;
    logic                       d_r2_s;
    logic [CNT_W-1:0]           free_cnt_nxt_s;

    assign clear_s     = reset || rs.squash;
    assign disp_fire_s = rs.disp_en && disp_ready_r;
    assign d_r1_s      = rs.disp_t1_rdy || (rs.cdb_en && (rs.cdb_tag == rs.disp_t1));
    assign d_r2_s      = rs.disp_t2_rdy || (rs.cdb_en && (rs.cdb_tag == rs.disp_t2));

    // CDB tag match per entry and per-entry readiness
    always_comb begin
        m1_s  = {RS_SZ{1'b0}};
        m2_s  = {RS_SZ{1'b0}};
        rdy_s = {RS_SZ{1'b0}};
        for (int i = 0; i < RS_SZ; i++) begin
            m1_s[i] = rs.cdb_en && (t1_r[i] == rs.cdb_tag);
            m2_s[i] = rs.cdb_en && (t2_r[i] == rs.cdb_tag);
`ifdef RS_CDB_BYPASS_EN
            rdy_s[i] = valid_r[i] && (r1_r[i] || m1_s[i]) && (r2_r[i] || m2_s[i]);
`else
            rdy_s[i] = valid_r[i] && r1_r[i] && r2_r[i];
`endif
        end
    end

    // Oldest-ready select per FU class; a busy class never gets a grant
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] best;
        issue_s = {RS_SZ{1'b0}};
        for (int f = 0; f < FU_TYPES; f++) begin
            found = 1'b0;
            best  = {IDX_W{1'b0}};
            for (int i = 0; i < RS_SZ; i++) begin
                if (rdy_s[i] && !rs.fu_busy[f] && (fu_r[i] == FU_W'(f)) &&
                    (!found || (rank_r[i] < rank_r[best]))) begin
                    found = 1'b1;
                    best  = IDX_W'(i);
                end else begin
                    found = found;
                end
            end
            sel_vld_s[f] = found;
            sel_idx_s[f] = best;
            if (found) begin
                issue_s[best] = 1'b1;
            end else begin
                issue_s = issue_s;
            end
        end
    end

    // Issue count, age compaction and new-entry rank
    always_comb begin
        n_iss_s = {CNT_W{1'b0}};
        for (int i = 0; i < RS_SZ; i++) begin
            n_iss_s = n_iss_s + CNT_W'(issue_s[i]);
        end
        for (int i = 0; i < RS_SZ; i++) begin
            dec_s[i] = {IDX_W{1'b0}};
            for (int j = 0; j < RS_SZ; j++) begin
                dec_s[i] = dec_s[i] + IDX_W'(issue_s[j] && (rank_r[j] < rank_r[i]));
            end
        end
        vcnt_s         = CNT_W'(RS_SZ) - free_cnt_r;
        new_rank_s     = IDX_W'(vcnt_s - n_iss_s);
        free_cnt_nxt_s = free_cnt_r + n_iss_s - CNT_W'(disp_fire_s);
    end

    // Lowest-index slot free in registered state
    always_comb begin
        free_idx_s = {IDX_W{1'b0}};
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Entry update: issue frees, dispatch fills, wakeup and rank compaction on survivors
    always_ff @(posedge clock) begin
        if (clear_s) begin
            valid_r <= {RS_SZ{1'b0}};
            r1_r    <= {RS_SZ{1'b0}};
            r2_r    <= {RS_SZ{1'b0}};
            for (int i = 0; i < RS_SZ; i++) begin
                fu_r[i]   <= {FU_W{1'b0}};
                t1_r[i]   <= {PREG_W{1'b0}};
                t2_r[i]   <= {PREG_W{1'b0}};
                dest_r[i] <= {PREG_W{1'b0}};
                rob_r[i]  <= {ROB_W{1'b0}};
                rank_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (issue_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (disp_fire_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i] <= 1'b1;
                    fu_r[i]    <= rs.disp_fu;
                    t1_r[i]    <= rs.disp_t1;
                    r1_r[i]    <= d_r1_s;
                    t2_r[i]    <= rs.disp_t2;
                    r2_r[i]    <= d_r2_s;
                    dest_r[i]  <= rs.disp_dest;
                    rob_r[i]   <= rs.disp_rob;
                    rank_r[i]  <= new_rank_s;
                end else if (valid_r[i]) begin
                    r1_r[i]   <= r1_r[i] || m1_s[i];
                    r2_r[i]   <= r2_r[i] || m2_s[i];
                    rank_r[i] <= rank_r[i] - dec_s[i];
                end else begin
                    valid_r[i] <= 1'b0;
                end
            end
        end
    end

    // Issue registers: one-cycle valid pulse, payload loaded from the granted entry
    always_ff @(posedge clock) begin
        if (clear_s) begin
            iss_valid_r <= {FU_TYPES{1'b0}};
            iss_dest_r  <= {(FU_TYPES*PREG_W){1'b0}};
            iss_t1_r    <= {(FU_TYPES*PREG_W){1'b0}};
            iss_t2_r    <= {(FU_TYPES*PREG_W){1'b0}};
            iss_rob_r   <= {(FU_TYPES*ROB_W){1'b0}};
        end else begin
            iss_valid_r <= sel_vld_s;
            for (int f = 0; f < FU_TYPES; f++) begin
                if (sel_vld_s[f]) begin
                    iss_dest_r[f*PREG_W +: PREG_W] <= dest_r[sel_idx_s[f]];
                    iss_t1_r[f*PREG_W +: PREG_W]   <= t1_r[sel_idx_s[f]];
                    iss_t2_r[f*PREG_W +: PREG_W]   <= t2_r[sel_idx_s[f]];
                    iss_rob_r[f*ROB_W +: ROB_W]    <= rob_r[sel_idx_s[f]];
                end else begin
                    iss_dest_r[f*PREG_W +: PREG_W] <= iss_dest_r[f*PREG_W +: PREG_W];
                end
            end
        end
    end

    // Occupancy tracking; disp_ready mirrors the registered free count
    always_ff @(posedge clock) begin
        if (clear_s) begin
            free_cnt_r   <= CNT_W'(RS_SZ);
            disp_ready_r <= 1'b1;
        end else begin
            free_cnt_r   <= free_cnt_nxt_s;
            disp_ready_r <= (free_cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign rs.free_cnt   = free_cnt_r;
    assign rs.disp_ready = disp_ready_r;
    assign rs.iss_valid  = iss_valid_r;
    assign rs.iss_dest   = iss_dest_r;
    assign rs.iss_t1     = iss_t1_r;
    assign rs.iss_t2     = iss_t2_r;
    assign rs.iss_rob    = iss_rob_r;
endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for rs_wakeup_select: vector table plus hand sequences for wakeup, full and squash cases.
module tb_rs_wakeup_select;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rs_wakeup_select_if #(.RS_SZ(8), .FU_TYPES(4), .PREG_W(6), .ROB_W(5)) rsif ();

    rs_wakeup_select #(.RS_SZ(8), .FU_TYPES(4), .PREG_W(6), .ROB_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .rs    (rsif.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       de;   logic [1:0] fu;
        logic [5:0] t1;   logic       r1;
        logic [5:0] t2;   logic       r2;
        logic [5:0] dest; logic [4:0] rob;
        logic       ce;   logic [5:0] tag;
        logic [3:0] busy; logic       sq;
        logic [3:0] e_valid; logic [3:0] e_free;
        logic [1:0] e_f;  logic [5:0] e_dest; logic [4:0] e_rob;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic de, logic [1:0] fu, logic [5:0] t1, logic r1, logic [5:0] t2, logic r2,
                               logic [5:0] dest, logic [4:0] rob, logic ce, logic [5:0] tag,
                               logic [3:0] busy, logic sq, logic [3:0] ev, logic [3:0] efree,
                               logic [1:0] ef, logic [5:0] edest, logic [4:0] erob);
        vec_t r;
        r.de = de; r.fu = fu; r.t1 = t1; r.r1 = r1; r.t2 = t2; r.r2 = r2;
        r.dest = dest; r.rob = rob; r.ce = ce; r.tag = tag; r.busy = busy; r.sq = sq;
        r.e_valid = ev; r.e_free = efree; r.e_f = ef; r.e_dest = edest; r.e_rob = erob;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic de, logic [1:0] fu, logic [5:0] t1, logic r1, logic [5:0] t2, logic r2,
                         logic [5:0] dest, logic [4:0] rob, logic ce, logic [5:0] tag,
                         logic [3:0] busy, logic sq);
        rsif.disp_en = de; rsif.disp_fu = fu;
        rsif.disp_t1 = t1; rsif.disp_t1_rdy = r1;
        rsif.disp_t2 = t2; rsif.disp_t2_rdy = r2;
        rsif.disp_dest = dest; rsif.disp_rob = rob;
        rsif.cdb_en = ce; rsif.cdb_tag = tag;
        rsif.fu_busy = busy; rsif.squash = sq;
    endtask

    task automatic idle(logic [3:0] busy);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 5'd0, 1'b0, 6'd0, busy, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // de fu t1 r1 t2 r2 dest rob ce tag busy sq | valid free f dest rob
        vecs.push_back(v(1, 0, 1, 1, 2, 1, 12,  3, 0, 0, 4'b0000, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0001, 8, 0, 12,  3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0000, 8, 0,  0,  0));
        vecs.push_back(v(1, 2, 4, 1, 9, 0, 20,  7, 1, 9, 4'b0000, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0100, 8, 2, 20,  7));
        vecs.push_back(v(1, 3, 1, 1, 2, 1, 30, 10, 0, 0, 4'b0000, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(1, 0, 3, 1, 4, 1, 31, 11, 0, 0, 4'b0000, 0, 4'b1000, 7, 3, 30, 10));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0001, 8, 0, 31, 11));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 40,  1, 0, 0, 4'b0001, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 41,  2, 0, 0, 4'b0001, 0, 4'b0000, 6, 0,  0,  0));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 42,  4, 0, 0, 4'b0000, 0, 4'b0001, 6, 0, 40,  1));
        // rob 12 lands in slot 0 but is youngest: issue order must follow age, not index
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 43, 12, 0, 0, 4'b0001, 0, 4'b0000, 5, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0001, 6, 0, 41,  2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0001, 7, 0, 42,  4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0001, 8, 0, 43, 12));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 50,  5, 0, 0, 4'b1111, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(1, 1, 1, 1, 1, 1, 51,  6, 0, 0, 4'b1111, 0, 4'b0000, 6, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0011, 8, 1, 51,  6));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 60,  8, 0, 0, 4'b1111, 0, 4'b0000, 7, 0,  0,  0));
        vecs.push_back(v(1, 0, 1, 1, 1, 1, 61,  9, 0, 0, 4'b0000, 1, 4'b0000, 8, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 4'b0000, 0, 4'b0000, 8, 0,  0,  0));

        idle(4'b0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_free_cnt", int'(rsif.free_cnt), 8);
        check("reset_disp_ready", int'(rsif.disp_ready), 1);
        check("reset_iss_valid", int'(rsif.iss_valid), 0);
        check("reset_iss_dest", int'(rsif.iss_dest), 0);

        foreach (vecs[k]) begin
            drive(vecs[k].de, vecs[k].fu, vecs[k].t1, vecs[k].r1, vecs[k].t2, vecs[k].r2,
                  vecs[k].dest, vecs[k].rob, vecs[k].ce, vecs[k].tag, vecs[k].busy, vecs[k].sq);
            tick();
            check($sformatf("vec%0d_iss_valid", k), int'(rsif.iss_valid), int'(vecs[k].e_valid));
            check($sformatf("vec%0d_free_cnt", k), int'(rsif.free_cnt), int'(vecs[k].e_free));
            if (vecs[k].e_valid != 4'b0000) begin
                check($sformatf("vec%0d_iss_dest", k), int'(rsif.iss_dest[vecs[k].e_f*6 +: 6]), int'(vecs[k].e_dest));
                check($sformatf("vec%0d_iss_rob", k), int'(rsif.iss_rob[vecs[k].e_f*5 +: 5]), int'(vecs[k].e_rob));
            end
        end

        // MULT waits on tag 5, CDB two cycles later
        drive(1'b1, 2'd1, 6'd5, 1'b0, 6'd6, 1'b1, 6'd33, 5'd9, 1'b0, 6'd0, 4'b0000, 1'b0);
        tick();
        check("wake_disp_free", int'(rsif.free_cnt), 7);
        idle(4'b0000);
        tick();
        check("wake_wait1", int'(rsif.iss_valid), 0);
        tick();
        check("wake_wait2", int'(rsif.iss_valid), 0);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 5'd0, 1'b1, 6'd5, 4'b0000, 1'b0);
        tick();
`ifdef RS_CDB_BYPASS_EN
        check("wake_cdb_edge", int'(rsif.iss_valid), 2);
        check("wake_dest", int'(rsif.iss_dest[11:6]), 33);
        check("wake_t1", int'(rsif.iss_t1[11:6]), 5);
        check("wake_t2", int'(rsif.iss_t2[11:6]), 6);
        check("wake_rob", int'(rsif.iss_rob[9:5]), 9);
        idle(4'b0000);
        tick();
        check("wake_after", int'(rsif.iss_valid), 0);
`else
        check("wake_cdb_edge", int'(rsif.iss_valid), 0);
        idle(4'b0000);
        tick();
        check("wake_after", int'(rsif.iss_valid), 2);
        check("wake_dest", int'(rsif.iss_dest[11:6]), 33);
        check("wake_t1", int'(rsif.iss_t1[11:6]), 5);
        check("wake_t2", int'(rsif.iss_t2[11:6]), 6);
        check("wake_rob", int'(rsif.iss_rob[9:5]), 9);
`endif
        check("wake_free", int'(rsif.free_cnt), 8);

        // Fill all 8 slots with blocked ALU ops, then a dropped 9th
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'(16 + k), 5'(k), 1'b0, 6'd0, 4'b0001, 1'b0);
            tick();
            check($sformatf("fill%0d_free", k), int'(rsif.free_cnt), 7 - k);
        end
        check("full_disp_ready", int'(rsif.disp_ready), 0);
        drive(1'b1, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd40, 5'd15, 1'b0, 6'd0, 4'b0001, 1'b0);
        tick();
        check("drop_free", int'(rsif.free_cnt), 0);
        check("drop_disp_ready", int'(rsif.disp_ready), 0);
        idle(4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("drain%0d_valid", k), int'(rsif.iss_valid), 1);
            check($sformatf("drain%0d_rob", k), int'(rsif.iss_rob[4:0]), k);
        end
        check("drain_free", int'(rsif.free_cnt), 8);
        tick();
        check("drain_empty", int'(rsif.iss_valid), 0);

        // Three ops waiting on tag 7, squashed; a later CDB must wake nothing
        drive(1'b1, 2'd0, 6'd7, 1'b0, 6'd1, 1'b1, 6'd20, 5'd1, 1'b0, 6'd0, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 2'd1, 6'd7, 1'b0, 6'd1, 1'b1, 6'd21, 5'd2, 1'b0, 6'd0, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 2'd2, 6'd1, 1'b1, 6'd7, 1'b0, 6'd22, 5'd3, 1'b0, 6'd0, 4'b0000, 1'b0);
        tick();
        check("sq_pre_free", int'(rsif.free_cnt), 5);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 5'd0, 1'b0, 6'd0, 4'b0000, 1'b1);
        tick();
        check("sq_free", int'(rsif.free_cnt), 8);
        check("sq_iss_valid", int'(rsif.iss_valid), 0);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 5'd0, 1'b1, 6'd7, 4'b0000, 1'b0);
        tick();
        check("sq_cdb_valid", int'(rsif.iss_valid), 0);
        idle(4'b0000);
        tick();
        check("sq_late_valid", int'(rsif.iss_valid), 0);
        check("sq_late_free", int'(rsif.free_cnt), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
